regfile_alu_hazard: RTL and testbench
=====================================

REGFILE_ALU_HAZARD -- requirements
Module: regfile_alu_hazard

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width in bits.
REQ-002 SHALL have parameter NREGS, default 32: number of architectural registers; address width is 5.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port we, input, 1: register-file write enable.
REQ-006 SHALL have ports rs1 and rs2, input, 5 each: read addresses; also the IF/ID source fields for hazard compare.
REQ-007 SHALL have port rd, input, 5: write address.
REQ-008 SHALL have port wd, input, XLEN: write data.
REQ-009 SHALL have ports rd1 and rd2, output, XLEN each: read data for rs1 and rs2.
REQ-010 SHALL have ports alu_a and alu_b, input, XLEN each: ALU operands.
REQ-011 SHALL have port alu_op, input, 4: ALU operation select.
REQ-012 SHALL have port alu_y, output, XLEN: ALU result.
REQ-013 SHALL have port alu_zero, output, 1: high when alu_y equals 0.
REQ-014 SHALL have port id_ex_memread, input, 1: the instruction in EX is a load.
REQ-015 SHALL have port id_ex_rd, input, 5: destination register of the instruction in EX.
REQ-016 SHALL have port stall, output, 1: load-use stall request.

Function
REQ-017 SHALL write wd into register rd at the rising clk edge when we=1, reset=1 and rd!=0.
REQ-018 SHALL ignore writes to x0; reads of address 0 on either port SHALL always return 0.
REQ-019 SHALL provide rd1 and rd2 as combinational reads with zero latency.
REQ-020 SHALL decode alu_op as follows, all results XLEN wide with carry and overflow discarded:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
- 5 SLL, 6 SRL, 7 SRA: shift amount is alu_b[4:0].
- 8 SLT (signed compare), 9 SLTU (unsigned compare): result is 1 or 0.
- 10 to 15: result 0.
REQ-021 SHALL implement the ALU as fully combinational; alu_zero SHALL be combinational from alu_y.
REQ-022 SHALL assert stall combinationally when all of the following hold: id_ex_memread=1, id_ex_rd!=0, and id_ex_rd equals rs1 or rs2.
REQ-023 SHALL never assert stall when id_ex_rd=0.

Reset
REQ-024 SHALL clear all registers to 0 immediately when reset falls, independent of clk.
REQ-025 SHALL block writes while reset=0; rd1 and rd2 SHALL read 0 during reset.
REQ-026 SHALL leave the ALU and the stall logic unaffected by reset; they are purely combinational.

Configuration
REQ-027 With macro REGFILE_BYPASS_EN defined, a read of address rd in the same cycle as an enabled write to rd (rd!=0) SHALL return wd on rd1 or rd2.
REQ-028 Without REGFILE_BYPASS_EN, such a read SHALL return the old contents until after the clock edge.

Structure
REQ-029 SHALL place XLEN, the register address width, the alu_op encodings (as a typedef/enum) and the NOP constant 32'h00000013 in package regfile_alu_hazard_pkg.
REQ-030 SHALL implement the ALU as the single sub-module rfah_alu; the register file and hazard logic SHALL live in the top module.

Verification
REQ-031 Write then read: we=1, rd=5, wd=32'hDEADBEEF, one edge, then rs1=5 -> rd1=32'hDEADBEEF.
REQ-032 x0 protection: we=1, rd=0, wd=32'hFFFFFFFF, one edge, then rs2=0 -> rd2=0.
REQ-033 ALU results:
- ADD 7+5 -> 12.
- SUB 5-7 -> 32'hFFFFFFFE.
- SRA 32'h80000000 by 4 -> 32'hF8000000.
- SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0.
- SUB 3-3 -> alu_zero=1.
REQ-034 Load-use hazard:
- id_ex_memread=1, id_ex_rd=3, rs2=3 -> stall=1.
- Same with id_ex_rd=0 -> stall=0.
- Same with id_ex_memread=0 -> stall=0.
REQ-035 Reset mid-operation: load x5=32'h12345678, drop reset between clock edges -> rd1 for rs1=5 reads 0 at once; a write attempted while reset=0 is discarded.
REQ-036 Bypass: we=1, rd=9, wd=32'hA5A5A5A5, rs1=9 in the same cycle -> rd1=32'hA5A5A5A5 with REGFILE_BYPASS_EN; old value 0 without it.

Source files
------------

// File: rtl/regfile_alu_hazard_pkg.sv
// Shared constants and types for the register file / ALU / hazard slice.
// Optional feature macro used by the top: REGFILE_BYPASS_EN.
package regfile_alu_hazard_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

endpackage

// File: rtl/regfile_alu_hazard_alu.sv
// Purely combinational ALU. Carry/overflow are dropped; undefined opcodes give 0.
module rfah_alu
   import regfile_alu_hazard_pkg::*;
#(
   parameter int XLEN = regfile_alu_hazard_pkg::XLEN
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [3:0]      op,
   output logic [XLEN-1:0] y,
   output logic            zero
);

   logic [4:0] shamt;

   assign shamt = b[4:0];

   // Operation decode.
   always_comb begin
      y = '0;
      case (alu_op_e'(op))
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_SLL:  y = a << shamt;
         ALU_SRL:  y = a >> shamt;
         ALU_SRA:  y = $signed(a) >>> shamt;
         ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
         default:  y = '0;
      endcase
   end

   assign zero = (y == '0);

endmodule

// File: rtl/regfile_alu_hazard.sv
// Register file (x0 hardwired to zero), ALU instance and load-use hazard detect.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_alu_hazard
   import regfile_alu_hazard_pkg::*;
#(
   parameter int XLEN  = regfile_alu_hazard_pkg::XLEN,
   parameter int NREGS = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   input  logic [REG_AW-1:0] rd,
   input  logic [XLEN-1:0]   wd,
   output logic [XLEN-1:0]   rd1,
   output logic [XLEN-1:0]   rd2,
   input  logic [XLEN-1:0]   alu_a,
   input  logic [XLEN-1:0]   alu_b,
   input  logic [3:0]        alu_op,
   output logic [XLEN-1:0]   alu_y,
   output logic              alu_zero,
   input  logic              id_ex_memread,
   input  logic [REG_AW-1:0] id_ex_rd,
   output logic              stall
);

   logic [XLEN-1:0] regs [NREGS];
   logic            wr_en;

   // Addresses beyond NREGS are treated like x0: never written, read as 0.
   assign wr_en = we && (rd != '0) && (32'(rd) < NREGS);

   // Register storage; async clear on reset assertion, writes only while out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[rd] <= wd;
      end
   end

   // Zero-latency read ports, forced to 0 during reset.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (reset) begin
         if (rs1 != '0 && 32'(rs1) < NREGS) rd1 = regs[rs1];
         if (rs2 != '0 && 32'(rs2) < NREGS) rd2 = regs[rs2];
`ifdef REGFILE_BYPASS_EN
         if (wr_en && rd == rs1) rd1 = wd;
         if (wr_en && rd == rs2) rd2 = wd;
`endif
      end
   end

   // Load-use hazard: the load in EX targets a source of the instruction in ID.
   assign stall = id_ex_memread && (id_ex_rd != '0) &&
                  ((id_ex_rd == rs1) || (id_ex_rd == rs2));

   rfah_alu #(.XLEN(XLEN)) u_alu (
      .a    (alu_a),
      .b    (alu_b),
      .op   (alu_op),
      .y    (alu_y),
      .zero (alu_zero)
   );

endmodule

// File: tb/tb_regfile_alu_hazard.sv
// Self-checking bench for regfile_alu_hazard: directed vectors, corner sequences
// and random stimulus against a behavioural model.
module tb_regfile_alu_hazard;

   logic        clk;
   logic        reset;
   logic        we;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] wd;
   logic [31:0] rd1, rd2;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_op;
   logic [31:0] alu_y;
   logic        alu_zero;
   logic        id_ex_memread;
   logic [4:0]  id_ex_rd;
   logic        stall;

   int checks   = 0;
   int failures = 0;

   logic [31:0] model [32];

   regfile_alu_hazard dut (
      .clk           (clk),
      .reset         (reset),
      .we            (we),
      .rs1           (rs1),
      .rs2           (rs2),
      .rd            (rd),
      .wd            (wd),
      .rd1           (rd1),
      .rd2           (rd2),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_op        (alu_op),
      .alu_y         (alu_y),
      .alu_zero      (alu_zero),
      .id_ex_memread (id_ex_memread),
      .id_ex_rd      (id_ex_rd),
      .stall         (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
      logic        zero;
   } alu_vec_t;

   typedef struct {
      string      name;
      logic       memread;
      logic [4:0] ex_rd;
      logic [4:0] s1;
      logic [4:0] s2;
      logic       exp_stall;
   } haz_vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference ALU from the opcode definitions, using plain arithmetic.
   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int unsigned sh;
      sh = int'(b) & 31;
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a << sh;
         4'd6: return a >> sh;
         4'd7: return a[31] ? ~((~a) >> sh) : (a >> sh);
         4'd8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd9: return (longint'({32'd0, a}) < longint'({32'd0, b})) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      we = 1'b1; rd = addr; wd = data;
      @(posedge clk);
      #1;
      we = 1'b0;
      if (reset && addr != 5'd0) model[addr] = data;
   endtask

   alu_vec_t alu_tab [8];
   haz_vec_t haz_tab [6];

   initial begin
      logic [31:0] exp_y;
      logic [4:0]  a1, a2;

      for (int i = 0; i < 32; i++) model[i] = 32'd0;

      alu_tab[0] = '{"add_7_5",   4'd0, 32'd7,        32'd5, 32'd12,         1'b0};
      alu_tab[1] = '{"sub_5_7",   4'd1, 32'd5,        32'd7, 32'hFFFF_FFFE,  1'b0};
      alu_tab[2] = '{"sra_min_4", 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0};
      alu_tab[3] = '{"slt_m1_1",  4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1,         1'b0};
      alu_tab[4] = '{"sltu_m1_1", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0,         1'b1};
      alu_tab[5] = '{"sub_3_3",   4'd1, 32'd3,        32'd3, 32'd0,          1'b1};
      alu_tab[6] = '{"srl_min_4", 4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0};
      alu_tab[7] = '{"op_12",     4'd12, 32'h1234,    32'h55, 32'd0,         1'b1};

      haz_tab[0] = '{"haz_rs2",     1'b1, 5'd3, 5'd7, 5'd3, 1'b1};
      haz_tab[1] = '{"haz_rd0",     1'b1, 5'd0, 5'd0, 5'd0, 1'b0};
      haz_tab[2] = '{"haz_noload",  1'b0, 5'd3, 5'd7, 5'd3, 1'b0};
      haz_tab[3] = '{"haz_rs1",     1'b1, 5'd9, 5'd9, 5'd1, 1'b1};
      haz_tab[4] = '{"haz_nomatch", 1'b1, 5'd4, 5'd5, 5'd6, 1'b0};
      haz_tab[5] = '{"haz_rd0_src", 1'b1, 5'd0, 5'd3, 5'd3, 1'b0};

      reset = 1'b0; we = 1'b0; rs1 = 5'd5; rs2 = 5'd0; rd = 5'd0; wd = 32'd0;
      alu_a = 32'd0; alu_b = 32'd0; alu_op = 4'd0;
      id_ex_memread = 1'b0; id_ex_rd = 5'd0;

      #2;
      check("reset_rd1", rd1, 32'd0);
      check("reset_stall", {31'd0, stall}, 32'd0);
      #10;
      reset = 1'b1;

      // Write then read back, x0 protection.
      write_reg(5'd5, 32'hDEAD_BEEF);
      rs1 = 5'd5; #1;
      check("wr_rd_x5", rd1, 32'hDEAD_BEEF);
      write_reg(5'd0, 32'hFFFF_FFFF);
      rs2 = 5'd0; #1;
      check("x0_rd2", rd2, 32'd0);

      // Directed ALU vectors.
      foreach (alu_tab[i]) begin
         alu_op = alu_tab[i].op; alu_a = alu_tab[i].a; alu_b = alu_tab[i].b;
         #1;
         check({alu_tab[i].name, "_y"}, alu_y, alu_tab[i].y);
         check({alu_tab[i].name, "_zero"}, {31'd0, alu_zero}, {31'd0, alu_tab[i].zero});
      end

      // Directed hazard vectors.
      foreach (haz_tab[i]) begin
         id_ex_memread = haz_tab[i].memread; id_ex_rd = haz_tab[i].ex_rd;
         rs1 = haz_tab[i].s1; rs2 = haz_tab[i].s2;
         #1;
         check(haz_tab[i].name, {31'd0, stall}, {31'd0, haz_tab[i].exp_stall});
      end

      // Random ALU against the reference model.
      for (int i = 0; i < 300; i++) begin
         alu_op = 4'($urandom_range(0, 15));
         alu_a  = $urandom;
         alu_b  = ($urandom_range(0, 7) == 0) ? alu_a : $urandom;
         #1;
         exp_y = alu_ref(alu_op, alu_a, alu_b);
         check("rand_alu_y", alu_y, exp_y);
         check("rand_alu_zero", {31'd0, alu_zero}, {31'd0, (exp_y == 32'd0)});
      end

      // Random hazard compare.
      for (int i = 0; i < 100; i++) begin
         id_ex_memread = 1'($urandom_range(0, 1));
         id_ex_rd = 5'($urandom_range(0, 3));
         rs1 = 5'($urandom_range(0, 3));
         rs2 = 5'($urandom_range(0, 3));
         #1;
         check("rand_stall", {31'd0, stall},
               {31'd0, (id_ex_memread && id_ex_rd != 0 && (id_ex_rd == rs1 || id_ex_rd == rs2))});
      end
      id_ex_memread = 1'b0;

      // Random writes and reads against the register model.
      for (int i = 0; i < 150; i++) begin
         write_reg(5'($urandom_range(0, 31)), $urandom);
         a1 = 5'($urandom_range(0, 31));
         a2 = 5'($urandom_range(0, 31));
         rs1 = a1; rs2 = a2; #1;
         check("rand_rd1", rd1, model[a1]);
         check("rand_rd2", rd2, model[a2]);
      end

      // Same-cycle read of the register being written.
      write_reg(5'd9, 32'd0);
      @(negedge clk);
      we = 1'b1; rd = 5'd9; wd = 32'hA5A5_A5A5; rs1 = 5'd9; rs2 = 5'd0;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("bypass_rd1", rd1, 32'hA5A5_A5A5);
`else
      check("bypass_rd1", rd1, 32'd0);
`endif
      check("bypass_rd2_x0", rd2, 32'd0);
      @(posedge clk); #1;
      we = 1'b0;
      model[9] = 32'hA5A5_A5A5;
      check("bypass_after_edge", rd1, 32'hA5A5_A5A5);

      // Reset mid-operation: async clear, write blocked while low.
      write_reg(5'd5, 32'h1234_5678);
      rs1 = 5'd5; #1;
      check("pre_reset_x5", rd1, 32'h1234_5678);
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      check("async_clear_rd1", rd1, 32'd0);
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      we = 1'b1; rd = 5'd5; wd = 32'hCAFE_F00D;
      alu_op = 4'd0; alu_a = 32'd2; alu_b = 32'd3;
      #1;
      check("alu_in_reset", alu_y, 32'd5);
      @(posedge clk); #1;
      check("rd1_in_reset", rd1, 32'd0);
      @(negedge clk);
      we = 1'b0;
      reset = 1'b1;
      #1;
      check("blocked_write_x5", rd1, 32'd0);
      rs2 = 5'd9; #1;
      check("cleared_x9", rd2, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation time %0t exceeded limit", $time);
      $fatal(1, "timeout");
   end

endmodule
